// File: rtl/cmp_arb_pkg.sv
// -----------------------------------------------------------------------------
// cmp_arb_pkg
// Shared definitions for the round-robin compare arbiter:
//   - state_t   : sequencer states (IDLE / CMP / RESP)
//   - N_DEF     : default number of requesters
//   - W_DEF     : default operand width
//   - FLAG_*    : bit positions inside the {greater, lesser, equal} flag vector
//   - next_ptr  : round-robin pointer advance with wrap at n-1
// -----------------------------------------------------------------------------
package cmp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int N_DEF = 4;
    localparam int W_DEF = 4;

    // Flag vector layout: {greater, lesser, equal}
    localparam int FLAG_GT = 2;
    localparam int FLAG_LT = 1;
    localparam int FLAG_EQ = 0;
    localparam int FLAG_W  = 3;

    // Pointer advance: winner + 1, wrapping from n-1 back to 0.
    function automatic int next_ptr(input int winner, input int n);
        return (winner >= n - 1) ? 0 : winner + 1;
    endfunction

endpackage

// File: rtl/cmp_core.sv
// -----------------------------------------------------------------------------
// cmp_core
// Purely combinational W-bit unsigned magnitude comparator.
// Ports:
//   a, b   : operands (unsigned, W bits)
//   flags  : {greater, lesser, equal}; exactly one bit is set for any input
// -----------------------------------------------------------------------------
module cmp_core
    import cmp_arb_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic [FLAG_W-1:0] flags
);

    always_comb begin
        flags          = '0;
        flags[FLAG_GT] = (a > b);
        flags[FLAG_LT] = (a < b);
        flags[FLAG_EQ] = (a == b);
    end

endmodule

// File: rtl/cmp_arbiter.sv
// -----------------------------------------------------------------------------
// cmp_arbiter
// Round-robin arbiter/sequencer sharing one W-bit magnitude comparator among
// N requesters. One request is served per three cycles at best:
//   IDLE -> grant + latch operands, CMP -> register flags, RESP -> handshake.
// Ports:
//   clk, rst           : rising-edge clock, asynchronous active-high reset
//   req   [N]          : level request per requester
//   a_in  [N*W]        : operand A, requester i in bits [i*W +: W]
//   b_in  [N*W]        : operand B, same packing
//   gnt   [N]          : one-hot grant, one cycle per accepted request
//   rsp_valid          : result (flags + id) valid
//   rsp_ready          : consumer accepts result
//   rsp_id [clog2(N)]  : index of the served requester
//   greater/lesser/equal : registered unsigned compare of the latched operands
// -----------------------------------------------------------------------------
module cmp_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       a_in,
    input  logic [N*W-1:0]       b_in,
    output logic [N-1:0]         gnt,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic                 greater,
    output logic                 lesser,
    output logic                 equal
);

    localparam int IDW = $clog2(N);

    state_t state, state_nxt;

    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    win_id;
    logic              win_found;
    logic [N-1:0]      win_onehot;
    logic [IDW-1:0]    ptr_nxt;

    logic [W-1:0]      a_p0;
    logic [W-1:0]      b_p0;
    logic [FLAG_W-1:0] flags_c;

    logic              grant_en;
    logic              cmp_en;
    logic              rsp_done;

    // Round-robin select: scan requesters starting at rr_ptr, wrapping at N-1,
    // and take the first one with req high.
    always_comb begin
        int k;
        win_found = 1'b0;
        win_id    = '0;
        k         = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!win_found && req[k]) begin
                win_found = 1'b1;
                win_id    = IDW'(k);
            end
        end
    end

    always_comb begin
        win_onehot         = '0;
        win_onehot[win_id] = 1'b1;
        ptr_nxt            = IDW'(next_ptr(int'(win_id), N));
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencer next state and per-state enables
    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        cmp_en    = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_en  = 1'b1;
                    state_nxt = CMP;
                end
            end
            CMP: begin
                cmp_en    = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                // rsp_ready only matters while a result is being offered.
                if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stage p0: grant and operand latch at the IDLE edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt    <= '0;
            rsp_id <= '0;
            rr_ptr <= '0;
            a_p0   <= '0;
            b_p0   <= '0;
        end else begin
            // gnt is only ever high for the single cycle spent in CMP.
            gnt <= grant_en ? win_onehot : '0;
            if (grant_en) begin
                a_p0   <= a_in[int'(win_id)*W +: W];
                b_p0   <= b_in[int'(win_id)*W +: W];
                rsp_id <= win_id;
                rr_ptr <= ptr_nxt;
            end
        end
    end

    cmp_core #(
        .W (W)
    ) u_cmp_core (
        .a     (a_p0),
        .b     (b_p0),
        .flags (flags_c)
    );

    // Stage p1: compare result registered at the CMP edge, held through RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            greater   <= 1'b0;
            lesser    <= 1'b0;
            equal     <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            if (cmp_en) begin
                greater   <= flags_c[FLAG_GT];
                lesser    <= flags_c[FLAG_LT];
                equal     <= flags_c[FLAG_EQ];
                rsp_valid <= 1'b1;
            end else if (rsp_done) begin
                // Flags deliberately keep their value after the handshake.
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
module tb_cmp_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   gnt;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic           greater;
    logic           lesser;
    logic           equal;

    int n_chk;
    int n_err;

    // Expected {greater, lesser, equal} for the rotation test operands
    logic [2:0] expf [4] = '{3'b100, 3'b010, 3'b001, 3'b100};

    cmp_arbiter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .greater   (greater),
        .lesser    (lesser),
        .equal     (equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_gnt"},   32'(gnt),       32'h0);
        check({tag, "_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_id"},    32'(rsp_id),    32'h0);
        check({tag, "_flags"}, 32'({greater, lesser, equal}), 32'h0);
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req       = '0;
        a_in      = '0;
        b_in      = '0;
        rsp_ready = 1'b1;

        // Reset state
        tick();
        check_idle_outs("reset");
        rst = 1'b0;
        tick();

        // Single request: requester 0, A > B
        set_op(0, 4'hA, 4'h5);
        req = 4'b0001;
        tick();
        check("single_gnt", 32'(gnt), 32'h1);
        check("single_valid_early", 32'(rsp_valid), 32'h0);
        req = 4'b0000;
        tick();
        check("single_gnt_clear", 32'(gnt), 32'h0);
        check("single_valid", 32'(rsp_valid), 32'h1);
        check("single_id", 32'(rsp_id), 32'h0);
        check("single_flags", 32'({greater, lesser, equal}), 32'b100);
        tick();
        check("single_valid_drop", 32'(rsp_valid), 32'h0);

        // Equal on requester 2 (rr_ptr = 1)
        set_op(2, 4'hB, 4'hB);
        req = 4'b0100;
        tick();
        check("eq_gnt", 32'(gnt), 32'h4);
        req = 4'b0000;
        tick();
        check("eq_valid", 32'(rsp_valid), 32'h1);
        check("eq_id", 32'(rsp_id), 32'h2);
        check("eq_flags", 32'({greater, lesser, equal}), 32'b001);
        tick();

        // Lesser on requester 2 (rr_ptr = 3, wraps to 2)
        set_op(2, 4'h1, 4'hF);
        req = 4'b0100;
        tick();
        check("lt_gnt", 32'(gnt), 32'h4);
        req = 4'b0000;
        tick();
        check("lt_id", 32'(rsp_id), 32'h2);
        check("lt_flags", 32'({greater, lesser, equal}), 32'b010);
        tick();

        // Wrap: rr_ptr = 3, req = 1001 -> 3 first, then 0
        set_op(3, 4'h9, 4'h2);
        req = 4'b1001;
        tick();
        check("wrap_gnt3", 32'(gnt), 32'h8);
        req = 4'b0001;
        tick();
        check("wrap_id3", 32'(rsp_id), 32'h3);
        check("wrap_flags3", 32'({greater, lesser, equal}), 32'b100);
        check("wrap_no_gnt_in_resp", 32'(gnt), 32'h0);
        tick();
        check("wrap_idle_gnt", 32'(gnt), 32'h0);
        check("wrap_idle_valid", 32'(rsp_valid), 32'h0);
        tick();
        check("wrap_gnt0", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        check("wrap_id0", 32'(rsp_id), 32'h0);
        tick();

        // Backpressure: requester 1, stall 5 cycles, requester 2 waits
        set_op(1, 4'h3, 4'h7);
        rsp_ready = 1'b0;
        req = 4'b0010;
        tick();
        check("bp_gnt", 32'(gnt), 32'h2);
        req = 4'b0100;
        tick();
        check("bp_valid", 32'(rsp_valid), 32'h1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_valid", 32'(rsp_valid), 32'h1);
            check("bp_hold_id", 32'(rsp_id), 32'h1);
            check("bp_hold_flags", 32'({greater, lesser, equal}), 32'b010);
            check("bp_hold_gnt", 32'(gnt), 32'h0);
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(rsp_valid), 32'h0);
        check("bp_release_gnt", 32'(gnt), 32'h0);
        check("bp_flags_kept", 32'({greater, lesser, equal}), 32'b010);
        tick();
        check("bp_next_gnt", 32'(gnt), 32'h4);
        req = 4'b0000;
        tick();
        check("bp_next_id", 32'(rsp_id), 32'h2);
        tick();

        // Async reset while in CMP (rr_ptr = 3, req 0010 -> requester 1)
        req = 4'b0010;
        tick();
        check("rst_pre_gnt", 32'(gnt), 32'h2);
        rst = 1'b1;
        #1;
        check_idle_outs("rst_async");
        req = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
        check("rst_no_valid", 32'(rsp_valid), 32'h0);
        tick();
        check("rst_no_valid2", 32'(rsp_valid), 32'h0);

        // All four requesting continuously from rr_ptr = 0
        set_op(0, 4'hA, 4'h5);
        set_op(1, 4'h3, 4'h7);
        set_op(2, 4'hB, 4'hB);
        set_op(3, 4'hF, 4'h0);
        req = 4'b1111;
        for (int j = 0; j < 15; j++) begin
            tick();
            if (j % 3 == 0) begin
                check("rr_gnt", 32'(gnt), 32'(1 << ((j / 3) % 4)));
                check("rr_valid_low", 32'(rsp_valid), 32'h0);
            end else if (j % 3 == 1) begin
                check("rr_gnt_low", 32'(gnt), 32'h0);
                check("rr_valid", 32'(rsp_valid), 32'h1);
                check("rr_id", 32'(rsp_id), 32'((j / 3) % 4));
                check("rr_flags", 32'({greater, lesser, equal}), 32'(expf[(j / 3) % 4]));
            end else begin
                check("rr_idle_gnt", 32'(gnt), 32'h0);
                check("rr_idle_valid", 32'(rsp_valid), 32'h0);
            end
        end
        req = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Round-robin arbiter and sequencer that shares a single W-bit magnitude comparator among N requesters in the ALU. Each requester presents an operand pair with a request line; the arbiter grants one requester at a time, latches its operands, runs the compare, and returns registered Greater/Lesser/Equal flags tagged with the requester ID under a valid/ready handshake. It sits between the ALU issue logic and the shared compare datapath.

## Interface
- N, 4, number of requesters (2..8)
- W, 4, operand width in bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  N  per-requester compare request, level
- a_in  input  N*W  operand A per requester; requester i occupies bits [i*W +: W]
- b_in  input  N*W  operand B per requester, same packing
- gnt  output  N  one-hot grant, high for exactly one cycle per accepted request
- rsp_valid  output  1  result flags and ID are valid
- rsp_ready  input  1  consumer accepts the result
- rsp_id  output  $clog2(N)  index of the served requester
- greater  output  1  latched A > B (unsigned)
- lesser  output  1  latched A < B (unsigned)
- equal  output  1  latched A == B

## Operation
- FSM states: IDLE, CMP, RESP.
- IDLE: if req != 0, select the first set bit at or after rr_ptr, wrapping from N-1 to 0. At that edge: latch a/b of the winner, set gnt to its one-hot code, load rsp_id, set rr_ptr = winner+1 mod N, go to CMP. If req == 0, stay.
- CMP: gnt is high this cycle only. The combinational compare on the latched operands is registered into greater/lesser/equal at the closing edge; rsp_valid set; go to RESP.
- RESP: hold rsp_valid, rsp_id and flags stable until rsp_ready is sampled high; at that edge clear rsp_valid and go to IDLE. Flags keep their last value after rsp_valid drops.
- Exactly one of greater/lesser/equal is 1 whenever rsp_valid is 1. Compare is unsigned over W bits.
- Requesters hold req and operands stable until they see their gnt bit. They may drop req in the gnt cycle. A req dropped before grant is not served. Requests arriving during CMP/RESP wait for IDLE.
- The arbiter never grants a requester whose req is low at the sampling edge.

## Timing
- Reset (async assert, deassert synchronized externally): state IDLE, gnt 0, rsp_valid 0, rsp_id 0, greater 0, lesser 0, equal 0, rr_ptr 0, operand registers 0.
- Latency: req sampled at edge E0 -> gnt high in cycle E0..E1 -> rsp_valid high from E1.
- Throughput: one compare per 3 cycles with rsp_ready held high. rsp_ready low stalls indefinitely in RESP.
- rsp_ready while rsp_valid is 0 is ignored.
- Reset mid-operation: any state returns to IDLE immediately. An in-flight result is discarded with no response, and rr_ptr returns to 0.
- All requesters requesting continuously: grants rotate 0,1,...,N-1,0. No requester waits more than N services.

## Structure
- Package cmp_arb_pkg: state encoding (IDLE=2'd0, CMP=2'd1, RESP=2'd2), default N/W constants, flag bit order {greater,lesser,equal}.
- Sub-module cmp_core: purely combinational W-bit unsigned magnitude compare producing the three flags, instanced once on the latched operands.
- Round-robin select is inline priority logic rotated by rr_ptr. No further sub-modules.

## Test plan
- Reset then single request: req=4'b0001, a0=4'hA, b0=4'h5 -> gnt=0001 for one cycle, then rsp_valid with rsp_id=0, greater=1, lesser=0, equal=0.
- Equal/lesser: requester 2, a=4'hB, b=4'hB -> equal=1, rsp_id=2. Then a=4'h1, b=4'hF -> lesser=1.
- All four request continuously with rsp_ready=1 -> gnt sequence 0001,0010,0100,1000,0001, spaced 3 cycles apart, each rsp_id matching.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> flags and rsp_id stable, no new gnt. Raise rsp_ready -> IDLE next cycle, next grant follows.
- Wrap and pointer: after serving requester 3 with req=4'b1001 -> next grant is requester 0, not 3.
- Async reset asserted in CMP with a pending result -> all outputs 0 immediately, no rsp_valid after release, next grant starts from requester 0.
